// File: rtl/snf_entry_alloc_pkg.sv
// Shared types and defaults for the SNF entry allocator.
package snf_entry_alloc_pkg;

    localparam int SNF_ENTRIES_NUM_DFLT = 4;

    typedef enum logic [1:0] {
        SNF_ENT_FREE = 2'b00,
        SNF_ENT_PEND = 2'b01,
        SNF_ENT_BUSY = 2'b10
    } snf_ent_state_e;

endpackage

// File: rtl/snf_lowest_one_idx.sv
// Lowest-set-bit to index encoder; for a one-hot input this is a plain one-hot encoder.
module snf_lowest_one_idx #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    assign o_any = |i_vec;

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/snf_entry_alloc.sv
// Entry allocator/tracker feeding the SNF QoS entry finder.
// Optional sticky protocol checker enabled by defining SNF_ALLOC_ERR_CHK_EN.
//
//  state | meaning
//  FREE  | entry unused, allocatable
//  PEND  | allocated, waiting for the finder pick and dispatch
//  BUSY  | dispatched, waiting for completion (dealloc)
module snf_entry_alloc
    import snf_entry_alloc_pkg::*;
#(
    parameter int ENTRIES_NUM = SNF_ENTRIES_NUM_DFLT,
    parameter int IDX_W       = $clog2(ENTRIES_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    output logic [IDX_W-1:0]       alloc_entry_idx,
    output logic [ENTRIES_NUM-1:0] req_entry_vec,
    output logic                   upd_start_entry,
    input  logic [ENTRIES_NUM-1:0] req_entry_ptr_sel,
    output logic                   dispatch_valid,
    input  logic                   dispatch_ready,
    output logic [IDX_W-1:0]       dispatch_entry_idx,
    input  logic                   dealloc_valid,
    input  logic [IDX_W-1:0]       dealloc_entry_idx,
    output logic [IDX_W:0]         free_cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   alloc_err
);

    snf_ent_state_e         r_ent_state [ENTRIES_NUM];
    snf_ent_state_e         w_ent_nxt   [ENTRIES_NUM];
    logic [IDX_W:0]         r_free_cnt;
    logic [ENTRIES_NUM-1:0] w_free_vec;
    logic [ENTRIES_NUM-1:0] w_pend_vec;
    logic [ENTRIES_NUM-1:0] w_sel_hit_vec;
    logic                   w_alloc_fire;
    logic                   w_disp_fire;
    logic                   w_dealloc_ok;

    always_comb begin
        w_free_vec = '0;
        w_pend_vec = '0;
        for (int i = 0; i < ENTRIES_NUM; i++) begin
            w_free_vec[i] = (r_ent_state[i] == SNF_ENT_FREE);
            w_pend_vec[i] = (r_ent_state[i] == SNF_ENT_PEND);
        end
    end

    assign req_entry_vec = w_pend_vec;
    // The finder's pick can lag our state; only picks that land on PEND count.
    assign w_sel_hit_vec = req_entry_ptr_sel & w_pend_vec;

    snf_lowest_one_idx #(
        .WIDTH (ENTRIES_NUM),
        .IDX_W (IDX_W)
    ) u_alloc_pick (
        .i_vec (w_free_vec),
        .o_any (alloc_ready),
        .o_idx (alloc_entry_idx)
    );

    snf_lowest_one_idx #(
        .WIDTH (ENTRIES_NUM),
        .IDX_W (IDX_W)
    ) u_disp_pick (
        .i_vec (w_sel_hit_vec),
        .o_any (dispatch_valid),
        .o_idx (dispatch_entry_idx)
    );

    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign w_disp_fire  = dispatch_valid & dispatch_ready;
    assign w_dealloc_ok = dealloc_valid & (r_ent_state[dealloc_entry_idx] == SNF_ENT_BUSY);

    // Held low in reset so the finder does not advance on a discarded cycle.
    assign upd_start_entry = rst & (w_disp_fire | ~dispatch_valid);

    assign free_cnt = r_free_cnt;
    assign full     = (r_free_cnt == '0);
    assign empty    = (r_free_cnt == (IDX_W + 1)'(ENTRIES_NUM));

    always_comb begin
        for (int i = 0; i < ENTRIES_NUM; i++) begin
            w_ent_nxt[i] = r_ent_state[i];
            if (w_alloc_fire && (alloc_entry_idx == IDX_W'(i))) begin
                w_ent_nxt[i] = SNF_ENT_PEND;
            end
            if (w_disp_fire && (dispatch_entry_idx == IDX_W'(i))) begin
                w_ent_nxt[i] = SNF_ENT_BUSY;
            end
            if (w_dealloc_ok && (dealloc_entry_idx == IDX_W'(i))) begin
                w_ent_nxt[i] = SNF_ENT_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES_NUM; i++) begin
                r_ent_state[i] <= SNF_ENT_FREE;
            end
            r_free_cnt <= (IDX_W + 1)'(ENTRIES_NUM);
        end else begin
            for (int i = 0; i < ENTRIES_NUM; i++) begin
                r_ent_state[i] <= w_ent_nxt[i];
            end
            r_free_cnt <= r_free_cnt - (IDX_W + 1)'(w_alloc_fire) + (IDX_W + 1)'(w_dealloc_ok);
        end
    end

`ifdef SNF_ALLOC_ERR_CHK_EN
    logic r_alloc_err;
    logic w_err_evt;

    assign w_err_evt = (dealloc_valid & ~w_dealloc_ok)
                     | (alloc_valid & full)
                     | (|(req_entry_ptr_sel & (req_entry_ptr_sel - 1'b1)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alloc_err <= 1'b0;
        end else if (w_err_evt) begin
            r_alloc_err <= 1'b1;
        end
    end

    assign alloc_err = r_alloc_err;
`else
    assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_snf_entry_alloc.sv
// Self-checking bench for snf_entry_alloc: entry-level reference model plus directed scenarios.
module tb_snf_entry_alloc;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int F  = 0;
    localparam int P  = 1;
    localparam int B  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] alloc_entry_idx;
    logic [N-1:0]  req_entry_vec;
    logic          upd_start_entry;
    logic [N-1:0]  req_entry_ptr_sel;
    logic          dispatch_valid;
    logic          dispatch_ready;
    logic [IW-1:0] dispatch_entry_idx;
    logic          dealloc_valid;
    logic [IW-1:0] dealloc_entry_idx;
    logic [IW:0]   free_cnt;
    logic          full;
    logic          empty;
    logic          alloc_err;

    always #5 clk = ~clk;

    snf_entry_alloc dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_entry_idx    (alloc_entry_idx),
        .req_entry_vec      (req_entry_vec),
        .upd_start_entry    (upd_start_entry),
        .req_entry_ptr_sel  (req_entry_ptr_sel),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_entry_idx (dispatch_entry_idx),
        .dealloc_valid      (dealloc_valid),
        .dealloc_entry_idx  (dealloc_entry_idx),
        .free_cnt           (free_cnt),
        .full               (full),
        .empty              (empty),
        .alloc_err          (alloc_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int m_st [N];
    bit m_err;

`ifdef SNF_ALLOC_ERR_CHK_EN
    localparam bit ERR_CHK = 1'b1;
`else
    localparam bit ERR_CHK = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_nfree();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_st[i] == F) c++;
        return c;
    endfunction

    function automatic int m_lowest(input int want, input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) if (m_st[i] == want && mask[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_pend();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_st[i] == P);
        return v;
    endfunction

    // Reference model: entry life cycle applied on each clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) m_st[i] = F;
            m_err = 1'b0;
        end else begin
            int ai;
            int di;
            bit dok;
            ai  = alloc_valid ? m_lowest(F, '1) : -1;
            di  = dispatch_ready ? m_lowest(P, req_entry_ptr_sel) : -1;
            dok = dealloc_valid && (m_st[dealloc_entry_idx] == B);
            if (ERR_CHK && ((dealloc_valid && !dok) || (alloc_valid && m_nfree() == 0)
                            || $countones(req_entry_ptr_sel) > 1))
                m_err = 1'b1;
            if (ai >= 0) m_st[ai] = P;
            if (di >= 0) m_st[di] = B;
            if (dok) m_st[dealloc_entry_idx] = F;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int nf;
            int ai;
            int di;
            nf = m_nfree();
            ai = m_lowest(F, '1);
            di = m_lowest(P, req_entry_ptr_sel);
            chk("free_cnt", 32'(free_cnt), 32'(nf));
            chk("full", 32'(full), 32'(nf == 0));
            chk("empty", 32'(empty), 32'(nf == N));
            chk("alloc_ready", 32'(alloc_ready), 32'(nf > 0));
            if (nf > 0) chk("alloc_entry_idx", 32'(alloc_entry_idx), 32'(ai));
            chk("req_entry_vec", 32'(req_entry_vec), 32'(m_pend()));
            chk("dispatch_valid", 32'(dispatch_valid), 32'(di >= 0));
            if (di >= 0) chk("dispatch_entry_idx", 32'(dispatch_entry_idx), 32'(di));
            chk("upd_start_entry", 32'(upd_start_entry),
                32'(rst && (di < 0 || dispatch_ready)));
            chk("alloc_err", 32'(alloc_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; alloc_valid = 1'b0; req_entry_ptr_sel = '0;
        dispatch_ready = 1'b0; dealloc_valid = 1'b0; dealloc_entry_idx = '0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_free_cnt", 32'(free_cnt), 32'd4);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_upd", 32'(upd_start_entry), 32'd0);
        chk("rst_err", 32'(alloc_err), 32'd0);

        // Fill all four entries
        rst = 1'b1;
        alloc_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_idx", 32'(alloc_entry_idx), 32'(k));
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(alloc_ready), 32'd0);
        chk("fill_vec", 32'(req_entry_vec), 32'b1111);

        // Dispatch entries 1 and 3 to leave PEND=0101
        dispatch_ready = 1'b1;
        req_entry_ptr_sel = 4'b0010; tick();
        req_entry_ptr_sel = 4'b1000; tick();
        req_entry_ptr_sel = 4'b0100; dispatch_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", 32'(dispatch_valid), 32'd1);
            chk("hold_idx", 32'(dispatch_entry_idx), 32'd2);
            chk("hold_upd", 32'(upd_start_entry), 32'd0);
            tick();
        end
        dispatch_ready = 1'b1;
        #1;
        chk("fire_upd", 32'(upd_start_entry), 32'd1);
        tick();
        req_entry_ptr_sel = '0; dispatch_ready = 1'b0;
        #1;
        chk("fire_vec", 32'(req_entry_vec), 32'b0001);

        // Stale pick
        req_entry_ptr_sel = 4'b0010;
        #1;
        chk("stale_valid", 32'(dispatch_valid), 32'd0);
        chk("stale_upd", 32'(upd_start_entry), 32'd1);
        tick();
        req_entry_ptr_sel = '0;

        // Full with same-cycle dealloc and alloc request
        dealloc_valid = 1'b1; dealloc_entry_idx = 2'd1; alloc_valid = 1'b1;
        #1;
        chk("fd_ready", 32'(alloc_ready), 32'd0);
        chk("fd_cnt0", 32'(free_cnt), 32'd0);
        tick();
        dealloc_valid = 1'b0;
        #1;
        chk("fd_cnt1", 32'(free_cnt), 32'd1);
        chk("fd_idx", 32'(alloc_entry_idx), 32'd1);
        tick();
        alloc_valid = 1'b0;

        // Free entry 3, then illegal dealloc of it
        dealloc_valid = 1'b1; dealloc_entry_idx = 2'd3;
        tick();
        tick();
        dealloc_valid = 1'b0;
        #1;
        chk("ill_cnt", 32'(free_cnt), 32'd1);
        chk("ill_vec", 32'(req_entry_vec), 32'b0011);
        chk("ill_err", 32'(alloc_err), 32'(ERR_CHK));

        // Reset during traffic: PEND 0,1 / BUSY 2 / FREE 3
        rst = 1'b0; alloc_valid = 1'b1; req_entry_ptr_sel = 4'b0001; dispatch_ready = 1'b1;
        dealloc_valid = 1'b1; dealloc_entry_idx = 2'd2;
        tick();
        alloc_valid = 1'b0; req_entry_ptr_sel = '0; dispatch_ready = 1'b0; dealloc_valid = 1'b0;
        #1;
        chk("mrst_cnt", 32'(free_cnt), 32'd4);
        chk("mrst_vec", 32'(req_entry_vec), 32'd0);
        chk("mrst_dv", 32'(dispatch_valid), 32'd0);
        chk("mrst_upd", 32'(upd_start_entry), 32'd0);
        chk("mrst_err", 32'(alloc_err), 32'd0);
        tick();
        rst = 1'b1;

        // Mixed traffic checked by the model only
        for (int k = 0; k < 80; k++) begin
            alloc_valid = 1'($urandom_range(0, 1));
            dispatch_ready = 1'($urandom_range(0, 1));
            req_entry_ptr_sel = ($urandom_range(0, 4) == 4) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
            dealloc_valid = 1'($urandom_range(0, 1));
            dealloc_entry_idx = 2'($urandom_range(0, 3));
            tick();
        end
        alloc_valid = 1'b0; dispatch_ready = 1'b0; req_entry_ptr_sel = '0; dealloc_valid = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
